// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit: single-cycle logic/arith/compare ops and an
// iterative one-bit-per-cycle shifter, with valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int unsigned XLEN = 32,
    localparam int unsigned SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSll  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSltu = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1101;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
    typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

    state_e            state_q, state_d;
    shift_e            sh_kind_q, sh_kind_d, sh_kind;
    logic [XLEN-1:0]   acc_q, acc_d, acc_shifted;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    logic [XLEN-1:0]   alu_res;
    logic              legal, is_shift, start_shift, accept, last_step;
    logic [SHW-1:0]    sh_amt;

    assign sh_amt      = op_b[SHW-1:0];
    assign start_shift = is_shift && (sh_amt != '0);
    assign accept      = in_valid && in_ready;
    assign last_step   = (cnt_q == SHW'(1));

    // Single-cycle operation decode; a zero-amount shift simply passes op_a through.
    always_comb begin
        alu_res  = '0;
        legal    = 1'b1;
        is_shift = 1'b0;
        sh_kind  = ShSll;
        case (alu_control)
            OpAnd:  alu_res = op_a & op_b;
            OpOr:   alu_res = op_a | op_b;
            OpAdd:  alu_res = op_a + op_b;
            OpXor:  alu_res = op_a ^ op_b;
            OpSub:  alu_res = op_a - op_b;
            OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OpSltu: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OpSll: begin
                is_shift = 1'b1;
                sh_kind  = ShSll;
                alu_res  = op_a;
            end
            OpSrl: begin
                is_shift = 1'b1;
                sh_kind  = ShSrl;
                alu_res  = op_a;
            end
            OpSra: begin
                is_shift = 1'b1;
                sh_kind  = ShSra;
                alu_res  = op_a;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (sh_kind_q)
            ShSll:   acc_shifted = {acc_q[XLEN-2:0], 1'b0};
            ShSrl:   acc_shifted = {1'b0, acc_q[XLEN-1:1]};
            default: acc_shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = start_shift ? StShift : StDone;
            end
            StShift: begin
                if (last_step) state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    if (accept) state_d = start_shift ? StShift : StDone;
                    else        state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs; out_ready -> in_ready is a deliberate combinational path
    always_comb begin
        in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
        out_valid = (state_q == StDone);
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sh_kind_d = sh_kind_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (accept) begin
            if (start_shift) begin
                acc_d     = op_a;
                cnt_d     = sh_amt;
                sh_kind_d = sh_kind;
            end else begin
                result_d  = alu_res;
                zero_d    = (alu_res == '0);
                illegal_d = !legal;
            end
        end else if (state_q == StShift) begin
            acc_d = acc_shifted;
            cnt_d = cnt_q - SHW'(1);
            if (last_step) begin
                result_d  = acc_shifted;
                zero_d    = (acc_shifted == '0);
                illegal_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            sh_kind_q <= ShSll;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sh_kind_q <= sh_kind_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations are queued when an op is
// driven and popped when out_valid is observed on the falling edge.
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            z;
        logic            ill;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] c, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        exp_t   e;
        int     sh;
        logic   shift;
        sh    = int'(b[4:0]);
        shift = 1'b0;
        e.ill = 1'b0;
        case (c)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0011: e.res = a ^ b;
            4'b0110: e.res = a - b;
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b0100: begin e.res = a << sh; shift = 1'b1; end
            4'b0101: begin e.res = a >> sh; shift = 1'b1; end
            4'b1101: begin e.res = $signed(a) >>> sh; shift = 1'b1; end
            default: begin e.res = '0; e.ill = 1'b1; end
        endcase
        e.z   = (e.res == '0);
        e.lat = (shift && sh != 0) ? sh + 1 : 1;
        return e;
    endfunction

    // Offer an op at the falling edge; returns at the falling edge after the accept edge.
    task automatic send(input logic [3:0] c, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input bit push);
        in_valid    = 1'b1;
        alu_control = c;
        op_a        = a;
        op_b        = b;
        if (push) sb.push_back(model(c, a, b));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 3 * XLEN) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_control = 4'h0;
        op_a        = '0;
        op_b        = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({out_valid, result, zero, illegal} !== {1'b0, 32'h0, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got v=%b r=%h z=%b i=%b want 0/0/0/0",
                     out_valid, result, zero, illegal);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    // Directed single-cycle ops, issued back to back with out_ready held high.
    task automatic test_single_cycle();
        logic [3:0]      c_t[10] = '{4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b0000,
                                     4'b0001, 4'b0011, 4'b0100, 4'b1111, 4'b1001};
        logic [XLEN-1:0] a_t[10] = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                     32'hF0F0F0F0, 32'hF0F00000, 32'h12345678, 32'h1,
                                     32'hDEADBEEF, 32'h1};
        logic [XLEN-1:0] b_t[10] = '{32'h1, 32'h5, 32'h1, 32'h1, 32'h0FF00FF0,
                                     32'h0000000F, 32'h12345678, 32'hFFFFFFE0,
                                     32'h12345678, 32'h1};
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(c_t[i], a_t[i], b_t[i], 1'b1);
            wait_out(lat);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL single_sb_empty: got 0 entries want 1");
                continue;
            end
            e = sb.pop_front();
            n_total++;
            if ({result, zero, illegal} !== {e.res, e.z, e.ill})
                $display("FAIL single_op%0d: got r=%h z=%b i=%b want r=%h z=%b i=%b",
                         i, result, zero, illegal, e.res, e.z, e.ill);
            else n_pass++;
            n_total++;
            if (lat != e.lat) $display("FAIL single_lat%0d: got %0d want %0d", i, lat, e.lat);
            else n_pass++;
        end
    endtask

    // SRA by 31: in_ready low during the shift, even with in_valid asserted.
    task automatic test_long_shift();
        exp_t e;
        int   lat;
        int   busy_bad;
        out_ready = 1'b1;
        @(negedge clk);
        send(4'b1101, 32'h80000000, 32'h0000001F, 1'b1);
        in_valid    = 1'b1;
        alu_control = 4'b0010;
        op_a        = 32'h11111111;
        lat         = 1;
        busy_bad    = 0;
        while (!out_valid && lat < 3 * XLEN) begin
            if (in_ready !== 1'b0) busy_bad++;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        n_total++;
        if (busy_bad != 0) $display("FAIL shift_busy: got %0d ready cycles want 0", busy_bad);
        else n_pass++;
        n_total++;
        if (lat != 32) $display("FAIL sra31_lat: got %0d want 32", lat);
        else n_pass++;
        n_total++;
        if ({result, zero, illegal} !== {e.res, e.z, e.ill} || result !== 32'hFFFFFFFF)
            $display("FAIL sra31_result: got %h want %h", result, 32'hFFFFFFFF);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        send(4'b0011, 32'hF0F0F0F0, 32'hFFFF0000, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            op_a        = $urandom;
            op_b        = $urandom;
            alu_control = 4'b0010;
            n_total++;
            if ({out_valid, in_ready, result, zero, illegal} !== {2'b10, e.res, e.z, e.ill}
                || result !== 32'h0F0FF0F0)
                $display("FAIL bp_hold%0d: got v=%b rdy=%b r=%h want v=1 rdy=0 r=%h",
                         k, out_valid, in_ready, result, 32'h0F0FF0F0);
            else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready);
        else n_pass++;
        send(4'b0010, 32'h2, 32'h3, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        n_total++;
        if (result !== 32'h5 || lat != 1)
            $display("FAIL bp_next_op: got r=%h lat=%0d want r=%h lat=1", result, lat, e.res);
        else n_pass++;
    endtask

    task automatic test_reset_midshift();
        exp_t e;
        int   lat;
        int   spurious;
        out_ready = 1'b1;
        @(negedge clk);
        send(4'b0101, 32'hF0000000, 32'h00000014, 1'b0);
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if ({out_valid, result, zero, illegal} !== {1'b0, 32'h0, 1'b0, 1'b0})
            $display("FAIL midshift_reset: got v=%b r=%h z=%b i=%b want 0/0/0/0",
                     out_valid, result, zero, illegal);
        else n_pass++;
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL midshift_ready: got %b want 1", in_ready);
        else n_pass++;
        spurious = 0;
        repeat (25) begin
            if (out_valid) spurious++;
            @(negedge clk);
        end
        n_total++;
        if (spurious != 0) $display("FAIL midshift_discard: got %0d valid cycles want 0", spurious);
        else n_pass++;
        send(4'b0010, 32'h2, 32'h3, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        n_total++;
        if (result !== e.res || lat != 1)
            $display("FAIL post_reset_add: got r=%h lat=%0d want r=%h lat=1", result, lat, e.res);
        else n_pass++;
    endtask

    // Random back-to-back ops, shifts included, with out_ready held high.
    task automatic test_back_to_back();
        logic [3:0] codes[12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                  4'b0110, 4'b0111, 4'b1000, 4'b1101, 4'b1111, 4'b1010};
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(codes[$urandom_range(11)], $urandom, $urandom, 1'b1);
            wait_out(lat);
            e = sb.pop_front();
            n_total++;
            if ({result, zero, illegal} !== {e.res, e.z, e.ill} || lat != e.lat)
                $display("FAIL b2b_op%0d: got r=%h z=%b i=%b lat=%0d want r=%h z=%b i=%b lat=%0d",
                         i, result, zero, illegal, lat, e.res, e.z, e.ill, e.lat);
            else n_pass++;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d want 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_cycle();
        test_long_shift();
        test_backpressure();
        test_reset_midshift();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
